// File: rtl/keydisp_pkg.sv
// Shared types and constants for the keypad digit display.
// Holds the mux FSM state enum, blank patterns and counter sizing.
package keydisp_pkg;

  typedef enum logic [1:0] {
    SHOW_R,
    GAP_R,
    SHOW_L,
    GAP_L
  } mux_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seven_seg_hex.sv
// Combinational hex to active-low seven-segment decoder.
// Ports: hex[3:0] in, seg[6:0] out as {g,f,e,d,c,b,a}, 0 = lit.
module seven_seg_hex (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/keypad_digit_display.sv
// Two-digit key history shown on a muxed active-low 7-seg pair.
// Ports: clk, rst (sync, high), key_code/key_valid in; seg, an,
// digit_right, digit_left, key_count out. KEYDISP_BLANK_EN darkens
// digits that were never loaded.
module keypad_digit_display
  import keydisp_pkg::*;
#(
  parameter int MUX_DIV     = 250,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] digit_right,
  output logic [3:0] digit_left,
  output logic [1:0] key_count
);

  localparam int CW = cnt_width(MUX_DIV, DEAD_CYCLES);
  localparam logic [CW-1:0] SHOW_LAST = CW'(MUX_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DEAD_CYCLES - 1);
  localparam bit NO_GAP = (DEAD_CYCLES == 0);

  mux_state_t    state;
  logic [CW-1:0] cnt;
  logic [3:0]    sel_digit;
  logic [6:0]    dec_seg;
  logic [6:0]    nxt_seg;
  logic [1:0]    nxt_an;
  logic          r_lit;
  logic          l_lit;

`ifdef KEYDISP_BLANK_EN
  assign r_lit = (key_count != 2'd0);
  assign l_lit = (key_count == 2'd2);
`else
  assign r_lit = 1'b1;
  assign l_lit = 1'b1;
`endif

  assign sel_digit = (state == SHOW_L) ? digit_left : digit_right;

  seven_seg_hex u_dec (
    .hex (sel_digit),
    .seg (dec_seg)
  );

  always_comb begin
    nxt_an  = AN_OFF;
    nxt_seg = SEG_OFF;
    unique case (state)
      SHOW_R: begin
        if (r_lit) begin
          nxt_an  = 2'b10;
          nxt_seg = dec_seg;
        end
      end
      SHOW_L: begin
        if (l_lit) begin
          nxt_an  = 2'b01;
          nxt_seg = dec_seg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      digit_right <= 4'h0;
      digit_left  <= 4'h0;
      key_count   <= 2'd0;
      state       <= SHOW_R;
      cnt         <= '0;
    end else begin
      if (key_valid) begin
        digit_left  <= digit_right;
        digit_right <= key_code;
        if (key_count != 2'd2)
          key_count <= key_count + 2'd1;
      end

      seg <= nxt_seg;
      an  <= nxt_an;

      cnt <= cnt + 1'b1;
      unique case (state)
        SHOW_R: if (cnt == SHOW_LAST) begin
          cnt   <= '0;
          state <= NO_GAP ? SHOW_L : GAP_R;
        end
        GAP_R: if (cnt == GAP_LAST) begin
          cnt   <= '0;
          state <= SHOW_L;
        end
        SHOW_L: if (cnt == SHOW_LAST) begin
          cnt   <= '0;
          state <= NO_GAP ? SHOW_R : GAP_L;
        end
        GAP_L: if (cnt == GAP_LAST) begin
          cnt   <= '0;
          state <= SHOW_R;
        end
        default: begin
          cnt   <= '0;
          state <= SHOW_R;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_digit_display.sv
// Bench for keypad_digit_display (MUX_DIV=4, DEAD_CYCLES=1).
// Reference model works from edge count since reset and key history.
module tb_keypad_digit_display;

  localparam int M = 4;
  localparam int D = 1;
  localparam int P = 2 * (M + D);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] digit_right;
  logic [3:0] digit_left;
  logic [1:0] key_count;

  keypad_digit_display #(
    .MUX_DIV     (M),
    .DEAD_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .seg         (seg),
    .an          (an),
    .digit_right (digit_right),
    .digit_left  (digit_left),
    .key_count   (key_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int k = 0;
  logic [3:0] mr = 4'h0;
  logic [3:0] ml = 4'h0;
  int mc = 0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] c);
    logic [1:0] ea;
    logic [6:0] es;
    bit lr, ll;
    int ph;
    rst = r;
    key_valid = v;
    key_code = c;
    @(posedge clk);
    #1;
    ea = 2'b11;
    es = 7'h7F;
    if (r) begin
      k = 0; mr = 4'h0; ml = 4'h0; mc = 0;
    end else begin
      k++;
      ph = (k - 1) % P;
`ifdef KEYDISP_BLANK_EN
      lr = (mc > 0);
      ll = (mc == 2);
`else
      lr = 1'b1;
      ll = 1'b1;
`endif
      if (ph < M) begin
        if (lr) begin ea = 2'b10; es = glyph[mr]; end
      end else if (ph >= M + D && ph < 2 * M + D) begin
        if (ll) begin ea = 2'b01; es = glyph[ml]; end
      end
      if (v) begin
        ml = mr;
        mr = c;
        if (mc < 2) mc++;
      end
    end
    chk("an", {6'd0, an}, {6'd0, ea});
    chk("seg", {1'b0, seg}, {1'b0, es});
    chk("digit_right", {4'd0, digit_right}, {4'd0, mr});
    chk("digit_left", {4'd0, digit_left}, {4'd0, ml});
    chk("key_count", {6'd0, key_count}, 8'(mc));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h5);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'hA);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h1);
    step(1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b1, 4'h3);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 4'h0);
    n = 0;
    while (!((k % P) >= M + D && (k % P) < 2 * M + D) && n < 20) begin
      step(1'b0, 1'b0, 4'h0);
      n++;
    end
    chk("reach_show_l", 8'(n < 20), 8'd1);
    step(1'b1, 1'b1, 4'h9);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h7);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_digit_display.md
# keypad_digit_display

Consumer at the far end of the keypad scanner's key interface. Each single-cycle `key_valid` pulse shifts `key_code` into a two-digit history: the newest key goes to the right digit and the previous one to the left. The block time-multiplexes both digits onto one shared, active-low, dual seven-segment display, with a dead gap between digits to prevent ghosting. It sits between the scanner and the board's segment and anode pins.

## Interface
- `MUX_DIV`, default 250: cycles each digit is lit; must be ≥1.
- `DEAD_CYCLES`, default 2: cycles with both anodes off between digits; 0 means no gap.
- `clk`  input  1  system clock, the same clock as the scanner.
- `rst`  input  1  reset; one clock; reset is synchronous and active-high.
- `key_code`  input  4  hex value of the key; sampled only when `key_valid` is 1.
- `key_valid`  input  1  one-cycle strobe meaning a new debounced key.
- `seg`  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`  output  2  anode enables, active-low, registered; `an[0]` is the right digit and `an[1]` the left digit.
- `digit_right`  output  4  newest key.
- `digit_left`  output  4  previous key.
- `key_count`  output  2  number of keys captured, saturating at 2.

## Operation
- Reset values:
  - `seg` = 7'h7F, `an` = 2'b11.
  - `digit_right` = `digit_left` = 4'h0, `key_count` = 0.
  - FSM = SHOW_R, mux counter = 0.
- Capture on `key_valid` = 1: `digit_left` ← `digit_right`, `digit_right` ← `key_code`, `key_count` ← min(`key_count` + 1, 2).
  - Valid strobes on consecutive cycles are each captured.
  - Capture happens in every FSM state, including the gaps.
- FSM states: SHOW_R, GAP_R, SHOW_L, GAP_L.
  - SHOW_R lasts `MUX_DIV` cycles, then goes to GAP_R.
  - GAP_R lasts `DEAD_CYCLES` cycles, then goes to SHOW_L.
  - SHOW_L and GAP_L behave the same, then return to SHOW_R.
  - If `DEAD_CYCLES` = 0, SHOW_R goes straight to SHOW_L and back.
- Mux counter:
  - Counts 0 up to (state length − 1).
  - Clears on every state change.
  - Width is $clog2(max(`MUX_DIV`, `DEAD_CYCLES`, 2)).
- Outputs per state:
  - SHOW_R: `an` = 2'b10, `seg` = decode(`digit_right`).
  - SHOW_L: `an` = 2'b01, `seg` = decode(`digit_left`).
  - GAP states: `an` = 2'b11, `seg` = 7'h7F.
- Decode examples: 0 → 7'h40, 1 → 7'h79, 5 → 7'h12, A → 7'h08, F → 7'h0E. All 16 codes are standard hex glyphs, with b and d in lowercase.
- Reset mid-operation: on the next edge every register returns to its reset value, and any `key_valid` in the reset cycle is dropped.
- Reset and `key_valid` in the same cycle: reset wins.

## Timing
- `key_valid` sampled at edge n:
  - `digit_*` and `key_count` change after edge n.
  - `seg` reflects the new value after edge n+1, if that digit is being shown.
- `seg` and `an` are registered and always change on the same edge. No cycle ever has two anodes low.
- Full mux period is 2·(`MUX_DIV` + `DEAD_CYCLES`) cycles.
- With `MUX_DIV` = 4 and `DEAD_CYCLES` = 1 after reset release:
  - The first edge loads SHOW_R outputs.
  - `an` = 10 for 4 cycles, then 11 for 1, then 01 for 4, then 11 for 1; the pattern repeats every 10 cycles.

## Configuration
- `KEYDISP_BLANK_EN` defined:
  - A digit that has never been loaded is dark, with its anode held high and `seg` = 7'h7F.
  - The right digit is dark while `key_count` = 0; the left digit is dark while `key_count` < 2.
  - The FSM still runs with unchanged timing.
- `KEYDISP_BLANK_EN` undefined: unloaded digits show "0" (7'h40).

## Structure
- Package `keydisp_pkg` holds:
  - enum `mux_state_t` {SHOW_R, GAP_R, SHOW_L, GAP_L};
  - constant `SEG_OFF` = 7'h7F;
  - constant `AN_OFF` = 2'b11.
- Sub-module `seven_seg_hex`: purely combinational, 4-bit input to 7-bit active-low output. It is instantiated once, fed by a digit-select mux.

## Test plan
- Reset: hold `rst` for 3 cycles → `an` = 11, `seg` = 7F, both digits 0, `key_count` = 0.
- Run with `MUX_DIV` = 4, `DEAD_CYCLES` = 1 and no keys → `an` sequence is 10×4, 11×1, 01×4, 11×1, repeating with period 10. With `KEYDISP_BLANK_EN` undefined, `seg` = 40 during both show phases.
- Keys 5 then A, with `key_valid` 20 cycles apart → `digit_left` = 5, `digit_right` = A. `seg` = 08 while `an` = 10 and 12 while `an` = 01; `key_count` = 2.
- Back-to-back strobes with 1, F, 3 on consecutive cycles → `digit_left` = F, `digit_right` = 3, `key_count` = 2 (saturated).
- With `KEYDISP_BLANK_EN` defined and one key 7 after reset → right digit shows 7'h78. The left phase shows `an` = 11 and `seg` = 7F.
- Assert `rst` in the same cycle as `key_valid` (code 9) during SHOW_L → `digit_right` = 0. The next edge gives `an` = 11 and `seg` = 7F, then SHOW_R restarts.
